argmax_seq_ctrl: RTL and testbench

Sequential classifier back-end for the FNN output layer. It accepts N_CLASSES output-neuron scores one per beat over a valid/ready stream. It tracks the running maximum score and its index, then presents the winning class index and score with a result handshake. This block replaces the single-shot combinational max finder for designs where the output layer emits neurons serially from a shared MAC.

---
 rtl/argmax_seq_ctrl.sv | 147 ++++++++++++++
 tb/tb_argmax_seq_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/argmax_seq_ctrl.sv
// argmax_seq_ctrl
// Sequential arg-max back-end for the FNN output layer. Scores arrive one per
// beat over a valid/ready stream (class index = beat number). The running
// maximum and its index are tracked. After N_CLASSES beats the winner is
// presented with a valid/ack handshake.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start           begin a frame (in IDLE, or in DONE together with result_ack)
//   abort           cancel the frame in progress (COLLECT only)
//   in_valid        score beat valid
//   in_data         score for the current class index
//   in_ready        high exactly while collecting
//   result_valid    winner available (DONE)
//   result_idx      winning class index
//   result_max      winning score
//   result_ack      consumer takes the result
//   busy            high while collecting or holding a result
module argmax_seq_ctrl #(
    parameter int unsigned N_CLASSES  = 10,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IDX_WIDTH  = 4,
    parameter bit          SIGNED     = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  result_valid,
    output logic [IDX_WIDTH-1:0]  result_idx,
    output logic [DATA_WIDTH-1:0] result_max,
    input  logic                  result_ack,
    output logic                  busy
);

    typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;

    state_e                state_q;
    logic [IDX_WIDTH-1:0]  count_q;
    logic [IDX_WIDTH-1:0]  best_idx_q;
    logic [DATA_WIDTH-1:0] best_q;
    logic                  in_ready_q;
    logic                  result_valid_q;
    logic [IDX_WIDTH-1:0]  result_idx_q;
    logic [DATA_WIDTH-1:0] result_max_q;
    logic                  busy_q;

    logic                  xfer;
    logic                  last_beat;
    logic                  greater;
    logic                  take;
    logic [DATA_WIDTH-1:0] best_nxt;
    logic [IDX_WIDTH-1:0]  best_idx_nxt;

    assign xfer      = in_valid & in_ready_q;
    assign last_beat = (count_q == IDX_WIDTH'(N_CLASSES - 1));

    always_comb begin
        if (SIGNED) begin
            greater = $signed(in_data) > $signed(best_q);
        end else begin
            greater = in_data > best_q;
        end
        // First beat loads unconditionally; later beats need a strict win so
        // ties keep the lowest index.
        take         = (count_q == '0) || greater;
        best_nxt     = take ? in_data : best_q;
        best_idx_nxt = take ? count_q : best_idx_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            count_q        <= '0;
            best_q         <= '0;
            best_idx_q     <= '0;
            in_ready_q     <= 1'b0;
            result_valid_q <= 1'b0;
            result_idx_q   <= '0;
            result_max_q   <= '0;
            busy_q         <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start && !abort) begin
                        state_q    <= StCollect;
                        count_q    <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                StCollect: begin
                    if (abort) begin
                        // A beat arriving with abort is dropped along with the frame.
                        state_q    <= StIdle;
                        count_q    <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end else if (xfer) begin
                        best_q     <= best_nxt;
                        best_idx_q <= best_idx_nxt;
                        if (last_beat) begin
                            state_q        <= StDone;
                            count_q        <= '0;
                            in_ready_q     <= 1'b0;
                            result_valid_q <= 1'b1;
                            result_idx_q   <= best_idx_nxt;
                            result_max_q   <= best_nxt;
                        end else begin
                            count_q <= count_q + IDX_WIDTH'(1);
                        end
                    end
                end
                StDone: begin
                    if (result_ack) begin
                        result_valid_q <= 1'b0;
                        if (start) begin
                            state_q    <= StCollect;
                            count_q    <= '0;
                            in_ready_q <= 1'b1;
                        end else begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q        <= StIdle;
                    count_q        <= '0;
                    in_ready_q     <= 1'b0;
                    result_valid_q <= 1'b0;
                    busy_q         <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign result_valid = result_valid_q;
    assign result_idx   = result_idx_q;
    assign result_max   = result_max_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_argmax_seq_ctrl.sv
// Directed bench for argmax_seq_ctrl: an unsigned and a signed instance share
// all stimulus; frame vectors come from a table, control corners are
// hand-written sequences.
module tb_argmax_seq_ctrl;

    localparam int N = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort, in_valid, result_ack;
    logic [7:0] in_data;
    logic       in_ready, result_valid, busy;
    logic [3:0] result_idx;
    logic [7:0] result_max;
    logic       in_ready_s, result_valid_s, busy_s;
    logic [3:0] result_idx_s;
    logic [7:0] result_max_s;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    argmax_seq_ctrl #(.N_CLASSES(10), .DATA_WIDTH(8), .IDX_WIDTH(4), .SIGNED(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .result_valid(result_valid), .result_idx(result_idx), .result_max(result_max),
        .result_ack(result_ack), .busy(busy)
    );

    argmax_seq_ctrl #(.N_CLASSES(10), .DATA_WIDTH(8), .IDX_WIDTH(4), .SIGNED(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_s),
        .result_valid(result_valid_s), .result_idx(result_idx_s), .result_max(result_max_s),
        .result_ack(result_ack), .busy(busy_s)
    );

    typedef struct packed {
        logic [9:0][7:0] beats;
        bit              bubbles;
        logic [3:0]      idx;    // expected, unsigned instance
        logic [7:0]      mx;
        logic [3:0]      idx_s;  // expected, signed instance
        logic [7:0]      mx_s;
    } vec_t;

    vec_t vec [6];

    function automatic logic [9:0][7:0] pack10(input logic [7:0] a0, a1, a2, a3, a4,
                                               a5, a6, a7, a8, a9);
        return {a9, a8, a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Starting at a negedge already in COLLECT, feed all beats of vec[i].
    task automatic feed(input int i, input bit poke_start);
        int beat = 0;
        int cyc  = 0;
        int rdy  = 0;
        while (beat < N && cyc < 200) begin
            bit v;
            v = vec[i].bubbles ? cyc[0] : 1'b1;
            if (in_ready) rdy++;
            in_valid = v;
            in_data  = vec[i].beats[beat];
            start    = poke_start && (beat == 3);
            @(negedge clk);
            if (v) beat++;
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        check($sformatf("v%0d beats_done", i), beat, N);
        check($sformatf("v%0d ready_cycles", i), rdy, vec[i].bubbles ? 2 * N : N);
        check($sformatf("v%0d result_valid", i), result_valid, 1);
        check($sformatf("v%0d in_ready_done", i), in_ready, 0);
        check($sformatf("v%0d busy_done", i), busy, 1);
        check($sformatf("v%0d idx", i), result_idx, vec[i].idx);
        check($sformatf("v%0d max", i), result_max, vec[i].mx);
        check($sformatf("v%0d idx_s", i), result_idx_s, vec[i].idx_s);
        check($sformatf("v%0d max_s", i), result_max_s, vec[i].mx_s);
    endtask

    task automatic start_frame();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Hold one extra cycle, then acknowledge back to IDLE.
    task automatic ack_to_idle(input int i);
        @(negedge clk);
        check($sformatf("v%0d valid_held", i), result_valid, 1);
        check($sformatf("v%0d idx_held", i), result_idx, vec[i].idx);
        result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
        check($sformatf("v%0d valid_after_ack", i), result_valid, 0);
        check($sformatf("v%0d busy_after_ack", i), busy, 0);
        check($sformatf("v%0d idx_after_ack", i), result_idx, vec[i].idx);
        check($sformatf("v%0d max_after_ack", i), result_max, vec[i].mx);
    endtask

    initial begin
        vec[0] = '{beats: pack10(9, 7, 6, 15, 13, 17, 20, 7, 1, 2), bubbles: 1'b0,
                   idx: 4'd6, mx: 8'd20, idx_s: 4'd6, mx_s: 8'd20};
        vec[1] = '{beats: pack10(5, 3, 17, 4, 17, 0, 17, 1, 2, 3), bubbles: 1'b1,
                   idx: 4'd2, mx: 8'd17, idx_s: 4'd2, mx_s: 8'd17};
        vec[2] = '{beats: pack10(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                                 8'hFF, 8'hFF), bubbles: 1'b0,
                   idx: 4'd0, mx: 8'hFF, idx_s: 4'd0, mx_s: 8'hFF};
        vec[3] = '{beats: pack10(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), bubbles: 1'b0,
                   idx: 4'd9, mx: 8'd1, idx_s: 4'd9, mx_s: 8'd1};
        // -3,-1,-128,-2,-1,-50,-7,-9,-4,-6: unsigned 0xFF at idx1 beats 0x80 too.
        vec[4] = '{beats: pack10(8'hFD, 8'hFF, 8'h80, 8'hFE, 8'hFF, 8'hCE, 8'hF9, 8'hF7,
                                 8'hFC, 8'hFA), bubbles: 1'b0,
                   idx: 4'd1, mx: 8'hFF, idx_s: 4'd1, mx_s: 8'hFF};
        vec[5] = '{beats: pack10(8'h0A, 8'h80, 8'h05, 8'h7F, 8'h00, 8'h90, 8'h01, 8'h02,
                                 8'h03, 8'h04), bubbles: 1'b0,
                   idx: 4'd5, mx: 8'h90, idx_s: 4'd3, mx_s: 8'h7F};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        in_data = 8'h00; result_ack = 1'b0;
        #3;
        check("reset in_ready", in_ready, 0);
        check("reset result_valid", result_valid, 0);
        check("reset busy", busy, 0);
        check("reset idx", result_idx, 0);
        check("reset max", result_max, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Start with abort held stays idle.
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start_with_abort in_ready", in_ready, 0);
        check("start_with_abort busy", busy, 0);

        for (int i = 0; i < 6; i++) begin
            start_frame();
            check($sformatf("v%0d in_ready_start", i), in_ready, 1);
            feed(i, 1'b0);
            ack_to_idle(i);
        end

        // Abort after 4 beats; the beat accompanying abort is discarded.
        start_frame();
        for (int b = 0; b < 4; b++) begin
            in_valid = 1'b1; in_data = 8'hC8;
            @(negedge clk);
        end
        in_valid = 1'b1; in_data = 8'hFF; abort = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; abort = 1'b0;
        check("abort in_ready", in_ready, 0);
        check("abort busy", busy, 0);
        repeat (12) @(negedge clk);
        check("abort no_result", result_valid, 0);
        check("abort idx_kept", result_idx, 4'd5);
        check("abort max_kept", result_max, 8'h90);

        // start during COLLECT ignored; start+ack in DONE chains a new frame.
        start_frame();
        feed(0, 1'b1);
        result_ack = 1'b1; start = 1'b1;
        @(negedge clk);
        result_ack = 1'b0; start = 1'b0;
        check("b2b in_ready", in_ready, 1);
        check("b2b result_valid", result_valid, 0);
        check("b2b busy", busy, 1);
        feed(3, 1'b0);
        ack_to_idle(3);

        // Asynchronous reset between edges in the middle of a frame.
        start_frame();
        for (int b = 0; b < 3; b++) begin
            in_valid = 1'b1; in_data = 8'h33;
            @(negedge clk);
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst in_ready", in_ready, 0);
        check("async_rst busy", busy, 0);
        check("async_rst result_valid", result_valid, 0);
        check("async_rst idx", result_idx, 0);
        check("async_rst max", result_max, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_frame();
        feed(0, 1'b0);
        ack_to_idle(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
